// File: rtl/adc_serial_capture_pkg.sv
// Shared constants for the SPI ADC capture front-end and the sample bank it feeds.
package adc_serial_capture_pkg;

    localparam int SAMPLE_WIDTH   = 12;
    localparam int DEF_CLK_DIV    = 4;
    localparam int DEF_FRAME_BITS = 16;
    localparam int DEF_DATA_BITS  = SAMPLE_WIDTH;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_SETUP = 3'd1;
    localparam logic [2:0] ST_SHIFT = 3'd2;
    localparam logic [2:0] ST_DONE  = 3'd3;
    localparam logic [2:0] ST_QUIET = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE  = ST_IDLE,
        S_SETUP = ST_SETUP,
        S_SHIFT = ST_SHIFT,
        S_DONE  = ST_DONE,
        S_QUIET = ST_QUIET
    } state_t;

endpackage

// File: rtl/adc_serial_capture_sclk_phase_counter.sv
// Half-period timer for the ADC serial clock; half_tick marks the last clk of each half.
module sclk_phase_counter
    import adc_serial_capture_pkg::*;
#(
    parameter int CLK_DIV = DEF_CLK_DIV
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic half_tick
);

    localparam int              CW   = $clog2(CLK_DIV);
    localparam logic [CW-1:0]   LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] count;

    // Free-running modulo-CLK_DIV counter, held at zero while cleared.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= {CW{1'b0}};
        end else if (count == LAST) begin
            count <= {CW{1'b0}};
        end else begin
            count <= count + CW'(1);
        end
    end

    assign half_tick = (count == LAST);

endmodule

// File: rtl/adc_serial_capture.sv
// SPI ADC frame capture: drives cs_n/sclk, shifts one frame in MSB-first and
// presents the low DATA_BITS as a sample with a one-cycle valid strobe.
module adc_serial_capture
    import adc_serial_capture_pkg::*;
#(
    parameter int CLK_DIV    = DEF_CLK_DIV,
    parameter int FRAME_BITS = DEF_FRAME_BITS,
    parameter int DATA_BITS  = DEF_DATA_BITS
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 sdata,
    output logic                 cs_n,
    output logic                 sclk,
    output logic                 busy,
    output logic [DATA_BITS-1:0] sample,
    output logic                 valid
);

    localparam int            BW       = $clog2(FRAME_BITS);
    localparam logic [BW-1:0] LAST_BIT = BW'(FRAME_BITS - 1);

    state_t                  state;
    logic [BW-1:0]           bit_cnt;
    logic [FRAME_BITS-1:0]   shreg;
    logic                    half_tick;
    logic                    phase_clear;

    // Holding the phase counter in IDLE and DONE aligns SETUP and QUIET to a fresh half-period.
    assign phase_clear = (state == S_IDLE) || (state == S_DONE);

    sclk_phase_counter #(
        .CLK_DIV (CLK_DIV)
    ) u_phase (
        .clk       (clk),
        .rst       (rst),
        .clear     (phase_clear),
        .half_tick (half_tick)
    );

    // Capture FSM; all outputs are registered and updated on state transitions.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            cs_n    <= 1'b1;
            sclk    <= 1'b0;
            busy    <= 1'b0;
            valid   <= 1'b0;
            sample  <= {DATA_BITS{1'b0}};
            bit_cnt <= {BW{1'b0}};
            shreg   <= {FRAME_BITS{1'b0}};
        end else begin
            valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    sclk <= 1'b0;
                    if (start) begin
                        state <= S_SETUP;
                        cs_n  <= 1'b0;
                        busy  <= 1'b1;
                    end else begin
                        cs_n  <= 1'b1;
                        busy  <= 1'b0;
                    end
                end
                S_SETUP: begin
                    if (half_tick) begin
                        state   <= S_SHIFT;
                        bit_cnt <= LAST_BIT;
                    end
                end
                S_SHIFT: begin
                    if (half_tick) begin
                        if (!sclk) begin
                            // Rising sclk edge samples the bit the ADC set up on the previous fall.
                            sclk  <= 1'b1;
                            shreg <= (shreg << 1) | FRAME_BITS'(sdata);
                        end else begin
                            sclk <= 1'b0;
                            if (bit_cnt == {BW{1'b0}}) begin
                                state  <= S_DONE;
                                cs_n   <= 1'b1;
                                valid  <= 1'b1;
                                sample <= shreg[DATA_BITS-1:0];
                            end else begin
                                bit_cnt <= bit_cnt - BW'(1);
                            end
                        end
                    end
                end
                S_DONE: begin
                    state   <= S_QUIET;
                    bit_cnt <= BW'(1);
                end
                S_QUIET: begin
                    // Two half-periods of quiet time, counted down with the idle bit counter.
                    if (half_tick) begin
                        if (bit_cnt == {BW{1'b0}}) begin
                            state <= S_IDLE;
                            busy  <= 1'b0;
                        end else begin
                            bit_cnt <= bit_cnt - BW'(1);
                        end
                    end
                end
                default: begin
                    state <= S_IDLE;
                    cs_n  <= 1'b1;
                    sclk  <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_adc_serial_capture.sv
// Randomized self-checking bench for adc_serial_capture with a behavioural ADC and timing model.
module tb_adc_serial_capture;

    localparam int FB  = 16;
    localparam int DB  = 12;
    localparam int CD0 = 4;
    localparam int CD1 = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start0 = 1'b0, sdata0 = 1'b0, cs_n0, sclk0, busy0, valid0;
    logic start1 = 1'b0, sdata1 = 1'b0, cs_n1, sclk1, busy1, valid1;
    logic [DB-1:0] sample0, sample1;

    always #5 clk = ~clk;

    adc_serial_capture #(.CLK_DIV(CD0), .FRAME_BITS(FB), .DATA_BITS(DB)) dut0 (
        .clk(clk), .rst(rst), .start(start0), .sdata(sdata0), .cs_n(cs_n0),
        .sclk(sclk0), .busy(busy0), .sample(sample0), .valid(valid0));

    adc_serial_capture #(.CLK_DIV(CD1), .FRAME_BITS(FB), .DATA_BITS(DB)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .sdata(sdata1), .cs_n(cs_n1),
        .sclk(sclk1), .busy(busy1), .sample(sample1), .valid(valid1));

    int n_chk = 0;
    int n_pass = 0;
    int cyc = 0;

    logic [FB-1:0] frame_w [2];
    logic          p_sclk [2];
    logic          p_csn  [2];
    logic          p_busy [2];
    logic [DB-1:0] p_sample [2];
    int bit_idx [2];
    int rises [2];
    int nvalid [2];
    int valid_edge [2];
    int busy_fall_edge [2];
    int hold_viol [2];
    int rise_edge [2];
    int min_gap [2];
    int vq [$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    // ADC model (data changes on sclk falling edges) plus event recorder for one instance.
    task automatic adc_step(input int i, input logic csn, input logic sck, input logic vld,
                            input logic bsy, input logic [DB-1:0] smp, output logic sd);
        if (p_csn[i] && !csn) begin
            bit_idx[i] = FB - 1;
            if (rise_edge[i] >= 0 && (cyc - rise_edge[i]) < min_gap[i]) min_gap[i] = cyc - rise_edge[i];
        end else if (p_sclk[i] && !sck && !csn && bit_idx[i] > 0) begin
            bit_idx[i]--;
        end
        if (!p_csn[i] && csn) rise_edge[i] = cyc;
        sd = frame_w[i][bit_idx[i]];
        if (!p_sclk[i] && sck && !csn) rises[i]++;
        if (vld) begin
            nvalid[i]++;
            valid_edge[i] = cyc;
            if (i == 0) vq.push_back(cyc);
        end
        if (p_busy[i] && !bsy) busy_fall_edge[i] = cyc;
        if (!vld && !rst && smp !== p_sample[i]) hold_viol[i]++;
        p_csn[i] = csn;
        p_sclk[i] = sck;
        p_busy[i] = bsy;
        p_sample[i] = smp;
    endtask

    task automatic tick();
        logic sd;
        @(posedge clk);
        cyc++;
        #1;
        adc_step(0, cs_n0, sclk0, valid0, busy0, sample0, sd);
        sdata0 = sd;
        adc_step(1, cs_n1, sclk1, valid1, busy1, sample1, sd);
        sdata1 = sd;
    endtask

    task automatic set_start(input int i, input logic v);
        if (i == 0) start0 = v;
        else start1 = v;
    endtask

    function automatic logic [DB-1:0] smp_of(input int i);
        return (i == 0) ? sample0 : sample1;
    endfunction

    // One frame from a start pulse; optional extra starts at cycles 10 and 137 must be ignored.
    task automatic run_frame(input int i, input logic [FB-1:0] fr, input int cd,
                             input bit extra, input string tag);
        int t0;
        int budget;
        int p;
        int exp_v;
        logic [DB-1:0] exp_s;
        exp_v = 1 + cd + 2 * cd * FB;
        exp_s = fr[DB-1:0];
        frame_w[i] = fr;
        nvalid[i] = 0;
        rises[i] = 0;
        valid_edge[i] = -1;
        busy_fall_edge[i] = -1;
        set_start(i, 1'b1);
        tick();
        t0 = cyc;
        set_start(i, 1'b0);
        budget = 0;
        while (busy_fall_edge[i] < 0 && budget < 1000) begin
            p = cyc - t0 + 1;
            set_start(i, extra && (p == 10 || p == 137));
            tick();
            budget++;
        end
        set_start(i, 1'b0);
        chk({tag, "_done"}, busy_fall_edge[i] >= 0, 1);
        chk({tag, "_nvalid"}, nvalid[i], 1);
        chk({tag, "_valid_cyc"}, valid_edge[i] - t0 + 1, exp_v);
        chk({tag, "_sample"}, smp_of(i), exp_s);
        chk({tag, "_rises"}, rises[i], FB);
        chk({tag, "_busy_fall"}, busy_fall_edge[i] - t0 + 1, exp_v + 1 + 2 * cd);
        if (extra) begin
            repeat (5) tick();
            chk({tag, "_no_requeue"}, busy0, 0);
        end
    endtask

    task automatic held_test();
        int t0;
        int budget;
        int period;
        period = (1 + CD0 + 2 * CD0 * FB) + 1 + 2 * CD0;
        frame_w[0] = 16'h5A3C;
        nvalid[0] = 0;
        vq.delete();
        min_gap[0] = 1000;
        start0 = 1'b1;
        tick();
        t0 = cyc;
        budget = 0;
        while (nvalid[0] < 3 && budget < 600) begin
            tick();
            budget++;
        end
        start0 = 1'b0;
        busy_fall_edge[0] = -1;
        budget = 0;
        while (busy_fall_edge[0] < 0 && budget < 100) begin
            tick();
            budget++;
        end
        chk("held_nvalid", nvalid[0], 3);
        for (int k = 0; k < 3; k++)
            chk($sformatf("held_valid%0d", k), (vq.size() > k) ? vq[k] - t0 + 1 : -1,
                (1 + CD0 + 2 * CD0 * FB) + k * period);
        chk("held_csn_gap", min_gap[0] >= 9, 1);
        chk("held_sample", sample0, 12'hA3C);
    endtask

    task automatic reset_test();
        int t0;
        frame_w[0] = 16'h0C3A;
        nvalid[0] = 0;
        start0 = 1'b1;
        tick();
        t0 = cyc;
        start0 = 1'b0;
        while (cyc - t0 + 1 < 60) tick();
        rst = 1'b1;
        tick();
        chk("rst_cs_n", cs_n0, 1);
        chk("rst_sclk", sclk0, 0);
        chk("rst_busy", busy0, 0);
        chk("rst_sample", sample0, 0);
        chk("rst_valid", valid0, 0);
        rst = 1'b0;
        repeat (160) tick();
        chk("rst_no_valid", nvalid[0], 0);
        run_frame(0, 16'h0C3A, CD0, 1'b0, "post_rst");
    endtask

    initial begin
        logic [FB-1:0] r;
        for (int i = 0; i < 2; i++) begin
            frame_w[i] = '0;
            p_sclk[i] = 1'b0;
            p_csn[i] = 1'b1;
            p_busy[i] = 1'b0;
            p_sample[i] = '0;
            bit_idx[i] = FB - 1;
            rises[i] = 0;
            nvalid[i] = 0;
            valid_edge[i] = -1;
            busy_fall_edge[i] = -1;
            hold_viol[i] = 0;
            rise_edge[i] = -1;
            min_gap[i] = 1000;
        end
        repeat (4) tick();
        chk("reset_cs_n", cs_n0, 1);
        chk("reset_sclk", sclk0, 0);
        chk("reset_busy", busy0, 0);
        chk("reset_valid", valid0, 0);
        chk("reset_sample", sample0, 0);
        rst = 1'b0;
        repeat (2) tick();

        run_frame(0, 16'h0A5C, CD0, 1'b0, "a5c");
        run_frame(0, 16'hFFFF, CD0, 1'b0, "ffff");
        run_frame(0, 16'h0000, CD0, 1'b0, "zero");
        chk("hold_between_valids", hold_viol[0], 0);
        r = 16'($urandom);
        run_frame(0, r, CD0, 1'b1, "extra_start");
        held_test();
        reset_test();
        for (int k = 0; k < 4; k++) begin
            r = 16'($urandom);
            run_frame(0, r, CD0, 1'b0, $sformatf("rand0_%0d", k));
        end
        run_frame(1, 16'h0123, CD1, 1'b0, "div2");
        for (int k = 0; k < 3; k++) begin
            r = 16'($urandom);
            run_frame(1, r, CD1, 1'b0, $sformatf("rand1_%0d", k));
        end
        chk("hold_final0", hold_viol[0], 0);
        chk("hold_final1", hold_viol[1], 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
